// File: rtl/gp_ram_arbiter_if.sv
// Per-port request/response bundle between a master (CPU or DMA/debug)
// and the gp_ram arbiter. The master holds req/wr/addr/wdata until gnt.
interface gp_ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, wr, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, wr, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/gp_ram_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port gp_ram.
// Port 0 is the CPU, port 1 the DMA/debug master. Commands are serialised
// onto the RAM; reads return data one cycle after the command with rvalid.
//
// state  | meaning
// IDLE   | no command outstanding; pick a winner when any req is high
// ACCESS | command on the RAM bus, gnt high; req inputs are stale and ignored
// RDATA  | read data from the RAM is returned with rvalid; req re-evaluated
module gp_ram_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  gp_ram_arbiter_if.slave   p0,
  gp_ram_arbiter_if.slave   p1,
  output logic              ram_cs,
  output logic              ram_wen,
  output logic              ram_oen,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

  state_t            state;
  logic              last;
  logic              sel;
  logic [1:0]        gnt_q;
  logic [1:0]        rvalid_q;

  logic              any_req;
  logic              win;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Winner selection: a lone requester always wins; ties go by mode.
  always_comb begin
    any_req = p0.req | p1.req;
    if (p0.req && p1.req) begin
      win = (PRIO_MODE != 0) ? 1'b0 : ~last;
    end else begin
      win = p1.req;
    end
    win_wr    = win ? p1.wr    : p0.wr;
    win_addr  = win ? p1.addr  : p0.addr;
    win_wdata = win ? p1.wdata : p0.wdata;
  end

  // Sequencer FSM with registered grant, read-valid and RAM command outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      sel         <= 1'b0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      ram_cs      <= 1'b0;
      ram_wen     <= 1'b0;
      ram_oen     <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      busy        <= 1'b0;
    end else begin
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      ram_cs      <= 1'b0;
      ram_wen     <= 1'b0;
      ram_oen     <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      case (state)
        IDLE, RDATA: begin
          if (any_req) begin
            state       <= ACCESS;
            busy        <= 1'b1;
            sel         <= win;
            last        <= win;
            gnt_q       <= win ? 2'b10 : 2'b01;
            ram_cs      <= 1'b1;
            ram_wen     <= win_wr;
            ram_oen     <= ~win_wr;
            ram_address <= win_addr;
            ram_data_in <= win_wr ? win_wdata : '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ACCESS: begin
          // ram_oen still holds the command being executed: high means a read.
          if (ram_oen) begin
            state    <= RDATA;
            busy     <= 1'b1;
            rvalid_q <= sel ? 2'b10 : 2'b01;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign p0.gnt    = gnt_q[0];
  assign p1.gnt    = gnt_q[1];
  assign p0.rvalid = rvalid_q[0];
  assign p1.rvalid = rvalid_q[1];
  assign p0.rdata  = rvalid_q[0] ? ram_data_out : '0;
  assign p1.rdata  = rvalid_q[1] ? ram_data_out : '0;

endmodule

// File: tb/tb_gp_ram_arbiter.sv
// Bench for gp_ram_arbiter: one round-robin instance and one fixed-priority
// instance, each in front of a behavioural 1-cycle registered-read RAM.
module tb_gp_ram_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  gp_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) a0 ();
  gp_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) a1 ();
  gp_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b0 ();
  gp_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b1 ();

  logic       a_cs, a_wen, a_oen, a_busy;
  logic [7:0] a_addr, a_din, a_dout;
  logic       b_cs, b_wen, b_oen, b_busy;
  logic [7:0] b_addr, b_din, b_dout;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] d20, d21;

  gp_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .p0(a0), .p1(a1),
    .ram_cs(a_cs), .ram_wen(a_wen), .ram_oen(a_oen),
    .ram_address(a_addr), .ram_data_in(a_din), .ram_data_out(a_dout),
    .busy(a_busy));

  gp_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .p0(b0), .p1(b1),
    .ram_cs(b_cs), .ram_wen(b_wen), .ram_oen(b_oen),
    .ram_address(b_addr), .ram_data_in(b_din), .ram_data_out(b_dout),
    .busy(b_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAMs with registered read.
  always @(posedge clk) begin
    if (a_cs && a_wen) mem_a[a_addr] <= a_din;
    if (a_cs && a_oen) a_dout <= mem_a[a_addr];
    if (b_cs && b_wen) mem_b[b_addr] <= b_din;
    if (b_cs && b_oen) b_dout <= mem_b[b_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic req, input logic wr,
                       input logic [7:0] addr, input logic [7:0] data);
    if (p == 0) begin
      a0.req = req; a0.wr = wr; a0.addr = addr; a0.wdata = data;
    end else begin
      a1.req = req; a1.wr = wr; a1.addr = addr; a1.wdata = data;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic do_write(input int p, input logic [7:0] addr, input logic [7:0] data);
    logic got;
    got = 1'b0;
    drive(p, 1'b1, 1'b1, addr, data);
    for (int i = 0; i < 8 && !got; i++) begin
      cyc();
      got = (p == 0) ? a0.gnt : a1.gnt;
    end
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("FAIL wr_gnt_timeout: port %0d addr %h got gnt=%b exp 1", p, addr, got);
    end
    drive(p, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a0.req = 1'b1; a0.wr = 1'b1; a0.addr = 8'h11; a0.wdata = 8'h22;
    a1.req = 1'b1; a1.wr = 1'b0; a1.addr = 8'h33; a1.wdata = 8'h44;
    b0.req = 1'b1; b0.wr = 1'b1; b0.addr = 8'h55; b0.wdata = 8'h66;
    b1.req = 1'b1; b1.wr = 1'b0; b1.addr = 8'h77; b1.wdata = 8'h88;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if ({a0.gnt, a1.gnt, a0.rvalid, a1.rvalid, a_cs, a_wen, a_oen, a_addr, a_din, a_busy} !== 30'd0) begin
        bad++;
        $display("FAIL reset_rr: cycle %0d outputs %b exp all 0", i,
                 {a0.gnt, a1.gnt, a0.rvalid, a1.rvalid, a_cs, a_wen, a_oen, a_addr, a_din, a_busy});
      end
      total++;
      if ({b0.gnt, b1.gnt, b0.rvalid, b1.rvalid, b_cs, b_wen, b_oen, b_addr, b_din, b_busy} !== 30'd0) begin
        bad++;
        $display("FAIL reset_fp: cycle %0d outputs %b exp all 0", i,
                 {b0.gnt, b1.gnt, b0.rvalid, b1.rvalid, b_cs, b_wen, b_oen, b_addr, b_din, b_busy});
      end
    end
    a0.req = 1'b0; a1.req = 1'b0; b0.req = 1'b0; b1.req = 1'b0;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_write_read();
    drive(0, 1'b1, 1'b1, 8'h10, 8'hA5);
    cyc();
    total++;
    if ({a0.gnt, a1.gnt, a_cs, a_wen, a_oen, a_addr, a_din, a_busy} !== {5'b10110, 8'h10, 8'hA5, 1'b1}) begin
      bad++;
      $display("FAIL wr_cmd: got %h exp %h", {a0.gnt, a1.gnt, a_cs, a_wen, a_oen, a_addr, a_din, a_busy},
               {5'b10110, 8'h10, 8'hA5, 1'b1});
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc();
    total++;
    if ({a0.gnt, a_cs, a_busy, a0.rvalid} !== 4'b0000) begin
      bad++;
      $display("FAIL wr_exit: got %b exp 0000", {a0.gnt, a_cs, a_busy, a0.rvalid});
    end
    drive(0, 1'b1, 1'b0, 8'h10, 8'h5A);
    cyc();
    total++;
    if ({a0.gnt, a1.gnt, a_cs, a_wen, a_oen, a_addr, a_din} !== {5'b10101, 8'h10, 8'h00}) begin
      bad++;
      $display("FAIL rd_cmd: got %h exp %h", {a0.gnt, a1.gnt, a_cs, a_wen, a_oen, a_addr, a_din},
               {5'b10101, 8'h10, 8'h00});
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc();
    total++;
    if ({a0.rvalid, a0.rdata, a1.rvalid, a1.rdata, a0.gnt, a_cs, a_busy} !== {1'b1, 8'hA5, 1'b0, 8'h00, 3'b001}) begin
      bad++;
      $display("FAIL rd_data: got %h exp %h", {a0.rvalid, a0.rdata, a1.rvalid, a1.rdata, a0.gnt, a_cs, a_busy},
               {1'b1, 8'hA5, 1'b0, 8'h00, 3'b001});
    end
    cyc();
    total++;
    if ({a0.rvalid, a0.rdata, a_busy} !== 10'd0) begin
      bad++;
      $display("FAIL rd_after: got %h exp 0", {a0.rvalid, a0.rdata, a_busy});
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] d0, d1;
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    pulse_rst();
    drive(0, 1'b1, 1'b1, 8'h01, d0);
    drive(1, 1'b1, 1'b1, 8'h02, d1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      total++;
      if ((k % 2) == 0) begin
        if ({a0.gnt, a1.gnt, a_addr, a_din} !== {2'b10, 8'h01, d0}) begin
          bad++;
          $display("FAIL rr_grant: grant %0d got %h exp %h", k, {a0.gnt, a1.gnt, a_addr, a_din}, {2'b10, 8'h01, d0});
        end
      end else begin
        if ({a0.gnt, a1.gnt, a_addr, a_din} !== {2'b01, 8'h02, d1}) begin
          bad++;
          $display("FAIL rr_grant: grant %0d got %h exp %h", k, {a0.gnt, a1.gnt, a_addr, a_din}, {2'b01, 8'h02, d1});
        end
      end
      cyc();
      total++;
      if ({a0.gnt, a1.gnt} !== 2'b00) begin
        bad++;
        $display("FAIL rr_gap: after grant %0d got %b exp 00", k, {a0.gnt, a1.gnt});
      end
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc();
  endtask

  task automatic test_fixed_prio();
    int   n0;
    logic got;
    n0 = 0;
    b0.req = 1'b1; b0.wr = 1'b1; b0.addr = 8'h30; b0.wdata = 8'($urandom);
    b1.req = 1'b1; b1.wr = 1'b1; b1.addr = 8'h33; b1.wdata = 8'($urandom);
    for (int i = 0; i < 19; i++) begin
      cyc();
      n0 += int'(b0.gnt);
      total++;
      if (b1.gnt !== 1'b0) begin
        bad++;
        $display("FAIL fp_starve: cycle %0d p1 gnt=%b exp 0", i, b1.gnt);
      end
    end
    total++;
    if (n0 != 10) begin
      bad++;
      $display("FAIL fp_p0_grants: got %0d exp 10", n0);
    end
    b0.req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      cyc();
      got = b1.gnt;
    end
    total++;
    if (got !== 1'b1 || b_addr !== 8'h33) begin
      bad++;
      $display("FAIL fp_p1_late: got gnt=%b addr=%h exp gnt=1 addr=33", got, b_addr);
    end
    b1.req = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_back_to_back();
    d20 = 8'($urandom);
    d21 = 8'($urandom);
    do_write(1, 8'h20, d20);
    do_write(0, 8'h21, d21);
    drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
    cyc();
    total++;
    if ({a1.gnt, a0.gnt, a_oen, a_addr} !== {3'b101, 8'h20}) begin
      bad++;
      $display("FAIL b2b_p1_cmd: got %h exp %h", {a1.gnt, a0.gnt, a_oen, a_addr}, {3'b101, 8'h20});
    end
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(0, 1'b1, 1'b0, 8'h21, 8'h00);
    cyc();
    total++;
    if ({a1.rvalid, a1.rdata, a0.gnt, a0.rvalid} !== {1'b1, d20, 2'b00}) begin
      bad++;
      $display("FAIL b2b_p1_data: got %h exp %h", {a1.rvalid, a1.rdata, a0.gnt, a0.rvalid}, {1'b1, d20, 2'b00});
    end
    cyc();
    total++;
    if ({a0.gnt, a1.rvalid, a_oen, a_addr} !== {3'b101, 8'h21}) begin
      bad++;
      $display("FAIL b2b_p0_cmd: got %h exp %h", {a0.gnt, a1.rvalid, a_oen, a_addr}, {3'b101, 8'h21});
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc();
    total++;
    if ({a0.rvalid, a0.rdata, a1.rvalid} !== {1'b1, d21, 1'b0}) begin
      bad++;
      $display("FAIL b2b_p0_data: got %h exp %h", {a0.rvalid, a0.rdata, a1.rvalid}, {1'b1, d21, 1'b0});
    end
    cyc();
  endtask

  task automatic test_reset_midread();
    drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
    cyc();
    total++;
    if ({a0.gnt, a_oen} !== 2'b11) begin
      bad++;
      $display("FAIL mid_rd_cmd: got %b exp 11", {a0.gnt, a_oen});
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++;
    if ({a0.gnt, a1.gnt, a0.rvalid, a1.rvalid, a0.rdata, a_cs, a_wen, a_oen, a_addr, a_din, a_busy} !== 38'd0) begin
      bad++;
      $display("FAIL mid_rst_out: got %h exp 0",
               {a0.gnt, a1.gnt, a0.rvalid, a1.rvalid, a0.rdata, a_cs, a_wen, a_oen, a_addr, a_din, a_busy});
    end
    cyc();
    total++;
    if ({a0.rvalid, a1.rvalid, a_busy} !== 3'b000) begin
      bad++;
      $display("FAIL mid_rst_norv: got %b exp 000", {a0.rvalid, a1.rvalid, a_busy});
    end
    drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
    cyc();
    total++;
    if ({a0.gnt, a1.gnt} !== 2'b10) begin
      bad++;
      $display("FAIL mid_rst_first: got %b exp 10", {a0.gnt, a1.gnt});
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc();
    total++;
    if ({a0.rvalid, a0.rdata} !== {1'b1, 8'hA5}) begin
      bad++;
      $display("FAIL mid_rst_rd0: got %h exp %h", {a0.rvalid, a0.rdata}, {1'b1, 8'hA5});
    end
    cyc();
    total++;
    if ({a0.gnt, a1.gnt} !== 2'b01) begin
      bad++;
      $display("FAIL mid_rst_second: got %b exp 01", {a0.gnt, a1.gnt});
    end
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc();
    total++;
    if ({a1.rvalid, a1.rdata} !== {1'b1, d20}) begin
      bad++;
      $display("FAIL mid_rst_rd1: got %h exp %h", {a1.rvalid, a1.rdata}, {1'b1, d20});
    end
    cyc();
  endtask

  // Random two-master traffic against a transaction-level model: memory
  // contents applied in grant order, round-robin fairness on ties, read data
  // one cycle after grant, bounded request latency.
  task automatic test_random();
    logic [7:0] mm [8];
    logic       pend [2];
    logic       pwr [2];
    logic [7:0] paddr [2];
    logic [7:0] pdata [2];
    int         age [2];
    logic       exp_rv [2];
    logic [7:0] exp_rd [2];
    logic       g [2];
    logic       prev_g;
    logic       tie;
    int         last_w;
    pulse_rst();
    for (int i = 0; i < 8; i++) begin
      mm[i] = 8'($urandom);
      do_write(0, 8'h40 + 8'(i), mm[i]);
    end
    last_w = 0;
    prev_g = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; pwr[p] = 1'b0; paddr[p] = 8'h40; pdata[p] = 8'h00;
      age[p] = 0; exp_rv[p] = 1'b0; exp_rd[p] = 8'h00;
    end
    for (int c = 0; c < 420; c++) begin
      cyc();
      g[0] = a0.gnt;
      g[1] = a1.gnt;
      total++;
      if ({a1.rvalid, a0.rvalid, a1.rdata, a0.rdata} !==
          {exp_rv[1], exp_rv[0], exp_rv[1] ? exp_rd[1] : 8'h00, exp_rv[0] ? exp_rd[0] : 8'h00}) begin
        bad++;
        $display("FAIL rnd_rdata: cycle %0d got %h exp %h", c, {a1.rvalid, a0.rvalid, a1.rdata, a0.rdata},
                 {exp_rv[1], exp_rv[0], exp_rv[1] ? exp_rd[1] : 8'h00, exp_rv[0] ? exp_rd[0] : 8'h00});
      end
      total++;
      if (a_busy !== (g[0] | g[1] | exp_rv[0] | exp_rv[1])) begin
        bad++;
        $display("FAIL rnd_busy: cycle %0d got %b exp %b", c, a_busy, g[0] | g[1] | exp_rv[0] | exp_rv[1]);
      end
      total++;
      if ((g[0] & g[1]) || (prev_g & (g[0] | g[1]))) begin
        bad++;
        $display("FAIL rnd_gnt_spacing: cycle %0d gnt %b%b prev %b exp no overlap", c, g[1], g[0], prev_g);
      end
      exp_rv[0] = 1'b0;
      exp_rv[1] = 1'b0;
      if (!g[0] && !g[1]) begin
        total++;
        if ({a_cs, a_wen, a_oen} !== 3'b000) begin
          bad++;
          $display("FAIL rnd_idle_bus: cycle %0d got %b exp 000", c, {a_cs, a_wen, a_oen});
        end
      end
      tie = pend[0] & pend[1];
      for (int p = 0; p < 2; p++) begin
        if (g[p]) begin
          total++;
          if (!pend[p]) begin
            bad++;
            $display("FAIL rnd_spurious_gnt: cycle %0d port %0d got gnt exp none", c, p);
          end
          total++;
          if ({a_cs, a_wen, a_oen, a_addr, a_din} !== {1'b1, pwr[p], ~pwr[p], paddr[p], pwr[p] ? pdata[p] : 8'h00}) begin
            bad++;
            $display("FAIL rnd_cmd: cycle %0d port %0d got %h exp %h", c, p, {a_cs, a_wen, a_oen, a_addr, a_din},
                     {1'b1, pwr[p], ~pwr[p], paddr[p], pwr[p] ? pdata[p] : 8'h00});
          end
          if (tie) begin
            total++;
            if (p == last_w) begin
              bad++;
              $display("FAIL rnd_rr_tie: cycle %0d got port %0d exp port %0d", c, p, 1 - last_w);
            end
          end
          last_w = p;
          if (pwr[p]) begin
            mm[paddr[p][2:0]] = pdata[p];
          end else begin
            exp_rv[p] = 1'b1;
            exp_rd[p] = mm[paddr[p][2:0]];
          end
          pend[p] = 1'b0;
          age[p] = 0;
        end else if (pend[p]) begin
          age[p]++;
          if (age[p] > 8) begin
            total++;
            bad++;
            $display("FAIL rnd_latency: cycle %0d port %0d waited %0d cycles exp <= 8", c, p, age[p]);
            pend[p] = 1'b0;
            age[p] = 0;
          end
        end
      end
      prev_g = g[0] | g[1];
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && c < 400 && ($urandom % 3) == 0) begin
          pend[p]  = 1'b1;
          pwr[p]   = 1'($urandom);
          paddr[p] = 8'h40 + 8'($urandom % 8);
          pdata[p] = 8'($urandom);
        end
        drive(p, pend[p], pwr[p], paddr[p], pdata[p]);
      end
    end
    total++;
    if (pend[0] || pend[1]) begin
      bad++;
      $display("FAIL rnd_drain: pending %b%b exp 00", pend[1], pend[0]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    a0.req = 1'b0; a0.wr = 1'b0; a0.addr = 8'h00; a0.wdata = 8'h00;
    a1.req = 1'b0; a1.wr = 1'b0; a1.addr = 8'h00; a1.wdata = 8'h00;
    b0.req = 1'b0; b0.wr = 1'b0; b0.addr = 8'h00; b0.wdata = 8'h00;
    b1.req = 1'b0; b1.wr = 1'b0; b1.addr = 8'h00; b1.wdata = 8'h00;
    #1;
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_prio();
    test_back_to_back();
    test_reset_midread();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, exp completion");
    $fatal(1, "watchdog");
  end

endmodule
